grid_memory_dpram_cfg: RTL
==========================

Name: grid_memory_dpram_cfg

Overview:
- Parametrised successor to the fixed 8-bit x 1K memory tile: simple dual-port RAM (one write port, one read port) with configurable depth and width.
- Runtime aspect-ratio mode: full width, or half width at double depth.
- Self-clearing init sequencer zeroes the array after every reset.
- Sits inside the memory physical tile, between the tile pins and the routing fabric. Single clock domain.

Parameters:
ADDR_WIDTH, 10, row address bits; array holds 2**ADDR_WIDTH rows.
DATA_WIDTH, 8, row width in bits; must be even and >= 2.

Ports:
clk  input  1  block clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
cfg_half_mode  input  1  0 = DATA_WIDTH x 2**ADDR_WIDTH; 1 = DATA_WIDTH/2 x 2**(ADDR_WIDTH+1). Static configuration bit.
memory_wen  input  1  write enable.
memory_waddr  input  ADDR_WIDTH+1  write address; MSB ignored in full mode.
memory_data_in  input  DATA_WIDTH  write data; upper half ignored in half mode.
memory_ren  input  1  read enable.
memory_raddr  input  ADDR_WIDTH+1  read address; MSB ignored in full mode.
memory_data_out  output  DATA_WIDTH  read data; upper half forced 0 in half mode.
memory_busy  output  1  high while the init sweep runs.

Behaviour:
- Reset (asynchronous, any time): memory_data_out=0, output pipeline stage=0, memory_busy=1, FSM=INIT, init counter=0. Array contents are not reset directly; the sweep clears them.
- FSM INIT:
  - Each cycle, write 0 to row init_cnt, then increment the counter.
  - After row 2**ADDR_WIDTH-1 is written, go to READY on the next edge. Sweep lasts exactly 2**ADDR_WIDTH cycles after reset release.
  - memory_busy=1 throughout; it drops on the same edge that enters READY.
  - memory_wen and memory_ren are ignored; memory_data_out stays 0.
- FSM READY: normal operation; stays in READY until reset.
- Reset asserted mid-sweep or mid-operation: immediate return to INIT with counter 0; sweep restarts from row 0.
- Address mapping:
  - Full mode: row = addr[ADDR_WIDTH-1:0], whole word.
  - Half mode: row = addr[ADDR_WIDTH:1], lane = addr[0]. Lane 0 = bits [DATA_WIDTH/2-1:0]; lane 1 = upper half.
- Write (READY, wen=1): on the edge, the row/lane is updated.
  - Full mode: whole row written from data_in.
  - Half mode: only the selected lane is written from data_in[DATA_WIDTH/2-1:0]; the other lane is unchanged.
- Read (READY, ren=1): memory_data_out updated on the next edge. Latency 1 cycle.
  - Half mode: selected lane on the low half, upper half zero.
  - ren=0: memory_data_out holds its previous value.
- Collision (same row and overlapping lane, wen and ren both high in the same cycle): read-first. data_out returns the pre-write contents; the write still commits. Half mode, same row, different lanes: no interaction.
- Address overflow is impossible: all ADDR_WIDTH+1 bits map to valid locations in every mode.
- cfg_half_mode change while READY: effective from the next edge. Contents are not reformatted; they are reinterpreted per the mapping above.

Optional Feature:
- Macro GRID_MEMORY_OUTPUT_REG_EN.
- Defined: an extra output register stage follows the read stage.
  - Read latency becomes 2 cycles.
  - The second stage loads only when the first stage loaded one cycle earlier (ren pipelined), so hold behaviour is preserved.
  - Reset clears both stages.
  - memory_busy timing is unchanged.
- Undefined: single stage, latency 1, as in Behaviour.

Test Plan:
- Init sweep (ADDR_WIDTH=4, DATA_WIDTH=8): release reset -> memory_busy=1 for exactly 16 cycles, then 0. Read all 16 rows -> 8'h00. A write of 8'hFF to row 3 with wen=1 during busy -> ignored; row 3 still reads 8'h00.
- Full-mode write/read: write 8'hA5 to addr 5, then ren at addr 5 -> 8'hA5 one cycle later (two cycles with GRID_MEMORY_OUTPUT_REG_EN). Then ren=0 for 3 cycles -> output holds 8'hA5.
- Collision: row 7 holds 8'h11; same cycle wen data 8'h22 and ren, both at addr 7 -> output 8'h11. Next read of addr 7 -> 8'h22.
- Half mode: write 4'h3 to addr 10 (row 5, lane 0) and 4'hC to addr 11 (row 5, lane 1). Read addr 10 -> 8'h03; read addr 11 -> 8'h0C. Switch to full mode, read addr 5 -> 8'hC3.
- Reset mid-sweep: assert reset at cycle 8 of the sweep for 1 cycle -> busy stays 1, sweep restarts, busy falls 16 cycles after the second release, memory_data_out=0 throughout.
- Reset mid-operation: output showing 8'hA5, assert reset asynchronously between edges -> memory_data_out=0 and memory_busy=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/grid_memory_dpram_cfg_if.sv
// Bus bundle for grid_memory_dpram_cfg: write port, read port, aspect-ratio config and busy flag.
// The master (tile pins / fabric side) drives requests; the slave (the RAM) returns read data and busy.
interface grid_memory_dpram_cfg_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
);
   logic                  cfg_half_mode;
   logic                  memory_wen;
   logic [ADDR_WIDTH:0]   memory_waddr;
   logic [DATA_WIDTH-1:0] memory_data_in;
   logic                  memory_ren;
   logic [ADDR_WIDTH:0]   memory_raddr;
   logic [DATA_WIDTH-1:0] memory_data_out;
   logic                  memory_busy;

   modport master (
      output cfg_half_mode, memory_wen, memory_waddr, memory_data_in,
      output memory_ren, memory_raddr,
      input  memory_data_out, memory_busy
   );

   modport slave (
      input  cfg_half_mode, memory_wen, memory_waddr, memory_data_in,
      input  memory_ren, memory_raddr,
      output memory_data_out, memory_busy
   );
endinterface

// File: rtl/grid_memory_dpram_cfg.sv
// Simple dual-port RAM tile with full/half-width aspect mode and a post-reset zeroing sweep.
// Optional second output register stage when GRID_MEMORY_OUTPUT_REG_EN is defined.
module grid_memory_dpram_cfg #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input logic                    clk,
   input logic                    reset,
   grid_memory_dpram_cfg_if.slave mem_if
);

   localparam int HALF = DATA_WIDTH / 2;
   localparam int ROWS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;
   localparam logic [DATA_WIDTH-1:0] LO_MASK  = {{HALF{1'b0}}, {HALF{1'b1}}};
   localparam logic [DATA_WIDTH-1:0] HI_MASK  = ~LO_MASK;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    busy;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_row;
   logic [DATA_WIDTH-1:0]   mem_wdata, mem_wmask;
   logic [ADDR_WIDTH-1:0]   wr_row, rd_row;
   logic                    wr_lane, rd_lane, rd_en;
   logic [DATA_WIDTH-1:0]   rdata_p1_q, rdata_p1_d;
   logic [DATA_WIDTH-1:0]   mem [ROWS];

   // In half mode the selected lane is returned right-aligned with the upper half zeroed.
   function automatic logic [DATA_WIDTH-1:0] lane_view(input logic [DATA_WIDTH-1:0] word,
                                                        input logic half, input logic lane);
      if (!half)     return word;
      else if (lane) return {{HALF{1'b0}}, word[DATA_WIDTH-1:HALF]};
      else           return {{HALF{1'b0}}, word[HALF-1:0]};
   endfunction

   always_comb begin
      wr_row  = mem_if.memory_waddr[ADDR_WIDTH-1:0];
      rd_row  = mem_if.memory_raddr[ADDR_WIDTH-1:0];
      wr_lane = 1'b0;
      rd_lane = 1'b0;
      if (mem_if.cfg_half_mode) begin
         wr_row  = mem_if.memory_waddr[ADDR_WIDTH:1];
         rd_row  = mem_if.memory_raddr[ADDR_WIDTH:1];
         wr_lane = mem_if.memory_waddr[0];
         rd_lane = mem_if.memory_raddr[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ROW) state_d = ST_READY;
         end
         ST_READY: state_d = ST_READY;
      endcase
   end

   // The sweep owns the write port while busy; user requests are ignored until READY.
   always_comb begin
      busy      = 1'b1;
      mem_we    = 1'b1;
      mem_row   = cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
      rd_en     = 1'b0;
      unique case (state_q)
         ST_INIT: ;
         ST_READY: begin
            busy      = 1'b0;
            mem_we    = mem_if.memory_wen;
            mem_row   = wr_row;
            rd_en     = mem_if.memory_ren;
            mem_wdata = mem_if.cfg_half_mode
                        ? {mem_if.memory_data_in[HALF-1:0], mem_if.memory_data_in[HALF-1:0]}
                        : mem_if.memory_data_in;
            if (mem_if.cfg_half_mode) mem_wmask = wr_lane ? HI_MASK : LO_MASK;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_row] <= (mem[mem_row] & ~mem_wmask) | (mem_wdata & mem_wmask);
   end

   // Stage p1: read-first capture of the pre-write row contents.
   always_comb begin
      rdata_p1_d = rdata_p1_q;
      if (rd_en) rdata_p1_d = lane_view(mem[rd_row], mem_if.cfg_half_mode, rd_lane);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata_p1_q <= '0;
      else       rdata_p1_q <= rdata_p1_d;
   end

`ifdef GRID_MEMORY_OUTPUT_REG_EN
   logic                  vld_p1_q, vld_p1_d;
   logic [DATA_WIDTH-1:0] rdata_p2_q, rdata_p2_d;

   // Stage p2: loads only behind a p1 load so idle cycles keep holding the last read.
   always_comb begin
      vld_p1_d   = rd_en;
      rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1_q   <= 1'b0;
         rdata_p2_q <= '0;
      end else begin
         vld_p1_q   <= vld_p1_d;
         rdata_p2_q <= rdata_p2_d;
      end
   end

   assign mem_if.memory_data_out = rdata_p2_q;
`else
   assign mem_if.memory_data_out = rdata_p1_q;
`endif

   assign mem_if.memory_busy = busy;

endmodule
